// File: rtl/hog_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hog_serializer_pkg
// Brief    : Shared defaults, beat geometry and output-FSM state encoding
//            for the HOG histogram serializer.
// Revision : 1.0 - initial release
// ============================================================================
package hog_serializer_pkg;

    localparam int HOG_BIT_WIDTH      = 12;
    localparam int HOG_NUM_BINS       = 9;
    localparam int HOG_NUM_BLOCKS     = 4;
    localparam int HOG_WORDS_PER_BEAT = HOG_NUM_BINS * HOG_NUM_BLOCKS;

    // Output controller: idle (nothing buffered) or streaming a beat
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } hog_state_t;

endpackage
`default_nettype wire

// File: rtl/hog_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : hog_serializer_if
// Brief    : Beat input, word output and status bundle of hog_serializer.
//            master = beat producer / word consumer, slave = serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface hog_serializer_if
    import hog_serializer_pkg::*;
#(
    parameter int BIT_WIDTH  = HOG_BIT_WIDTH,
    parameter int NUM_BINS   = HOG_NUM_BINS,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_BLK_W = BIT_WIDTH * NUM_BINS;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                 in_valid;
    logic [c_BLK_W-1:0]   in_block_0;
    logic [c_BLK_W-1:0]   in_block_1;
    logic [c_BLK_W-1:0]   in_block_2;
    logic [c_BLK_W-1:0]   in_block_3;
    logic                 ovf_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_sob;
    logic                 out_eob;
    logic                 out_sof;
    logic                 out_eof;
    logic                 ovf;
    logic [c_LVL_W-1:0]   fifo_level;

    modport master (
        output in_valid, in_block_0, in_block_1, in_block_2, in_block_3,
               ovf_clr, out_ready,
        input  out_valid, out_data, out_sob, out_eob, out_sof, out_eof,
               ovf, fifo_level
    );

    modport slave (
        input  in_valid, in_block_0, in_block_1, in_block_2, in_block_3,
               ovf_clr, out_ready,
        output out_valid, out_data, out_sob, out_eob, out_sof, out_eof,
               ovf, fifo_level
    );

endinterface
`default_nettype wire

// File: rtl/hog_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hog_beat_fifo
// Brief    : Beat-wide FIFO. Exposes the head entry and the entry behind it
//            so the serializer can roll into the next beat without a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module hog_beat_fifo #(
    parameter int WIDTH = 432,
    parameter int DEPTH = 4     // power of 2, at least 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic                         i_pop,
    input  wire logic [WIDTH-1:0]             i_wdata,
    output logic      [WIDTH-1:0]             o_head,
    output logic      [WIDTH-1:0]             o_next,
    output logic                              o_full,
    output logic                              o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]   o_level
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // Storage array; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); level tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
    assign o_head       = r_mem[r_rd_ptr];
    assign o_next       = r_mem[w_rd_ptr_nxt];
    assign o_full       = (r_level == c_FULL_LVL);
    assign o_empty      = (r_level == '0);
    assign o_level      = r_level;

endmodule
`default_nettype wire

// File: rtl/hog_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hog_serializer
// Brief    : Buffers 4-block HOG histogram beats and streams them out one
//            bin word per cycle with block/frame markers.
// Revision : 1.0 - initial release
// ============================================================================
module hog_serializer
    import hog_serializer_pkg::*;
#(
    parameter int BIT_WIDTH   = HOG_BIT_WIDTH,
    parameter int NUM_BINS    = HOG_NUM_BINS,
    parameter int NUM_BLOCKS  = HOG_NUM_BLOCKS,   // interface carries 4 blocks
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_BEATS = 8480
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hog_serializer_if.slave bus
);
    localparam int c_BLK_W     = BIT_WIDTH * NUM_BINS;
    localparam int c_BEAT_BITS = c_BLK_W * NUM_BLOCKS;
    localparam int c_WORDS     = NUM_BINS * NUM_BLOCKS;
    localparam int c_WORD_W    = $clog2(c_WORDS);
    localparam int c_BIN_W     = $clog2(NUM_BINS);
    localparam int c_BLKI_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int c_BEAT_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int c_LVL_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(c_WORDS - 1);
    localparam logic [c_BIN_W-1:0]  c_LAST_BIN  = c_BIN_W'(NUM_BINS - 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(FRAME_BEATS - 1);

    hog_state_t           r_state, w_state_nxt;
    logic [c_WORD_W-1:0]  r_word,  w_word_nxt;
    logic [c_BIN_W-1:0]   r_bin,   w_bin_nxt;
    logic [c_BLKI_W-1:0]  r_blk,   w_blk_nxt;
    logic [c_BEAT_W-1:0]  r_beat,  w_beat_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [BIT_WIDTH-1:0] r_data;
    logic                 r_sob, r_eob, r_sof, r_eof, r_ovf;

    logic [c_BEAT_BITS-1:0] w_in_data, w_head, w_next, w_src;
    logic [BIT_WIDTH-1:0]   w_word_sel;
    logic [c_LVL_W-1:0]     w_level;
    logic                   w_full, w_empty, w_load;
    logic                   w_xfer, w_last, w_pop, w_push, w_drop;
    int                     w_sel_idx;

    // Block 0 occupies the least-significant slice of the beat
    assign w_in_data = {bus.in_block_3, bus.in_block_2, bus.in_block_1, bus.in_block_0};

    // A full FIFO still takes a beat if the head is retiring this cycle
    assign w_xfer = r_valid & bus.out_ready;
    assign w_last = (r_word == c_LAST_WORD);
    assign w_pop  = w_xfer & w_last;
    assign w_push = bus.in_valid & (~w_full | w_pop);
    assign w_drop = bus.in_valid & w_full & ~w_pop;

    hog_beat_fifo #(
        .WIDTH (c_BEAT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_data),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Next state, counters, and which beat the next output word comes from
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_bin_nxt   = r_bin;
        w_blk_nxt   = r_blk;
        w_beat_nxt  = r_beat;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        w_src       = w_head;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    // Bypass the FIFO so word 0 is presented the next cycle
                    w_state_nxt = ST_SEND;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                    w_word_nxt  = '0;
                    w_bin_nxt   = '0;
                    w_blk_nxt   = '0;
                    w_src       = w_empty ? w_in_data : w_head;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_beat_nxt = (r_beat == c_LAST_BEAT) ? '0 : r_beat + c_BEAT_W'(1);
                        w_word_nxt = '0;
                        w_bin_nxt  = '0;
                        w_blk_nxt  = '0;
                        if (w_level > c_LVL_W'(1)) begin
                            w_load = 1'b1;
                            w_src  = w_next;
                        end else if (w_push) begin
                            w_load = 1'b1;
                            w_src  = w_in_data;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_word_nxt = r_word + c_WORD_W'(1);
                        w_load     = 1'b1;
                        if (r_bin == c_LAST_BIN) begin
                            w_bin_nxt = '0;
                            w_blk_nxt = r_blk + c_BLKI_W'(1);
                        end else begin
                            w_bin_nxt = r_bin + c_BIN_W'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bin k of a block is taken MSB-field first
    always_comb begin
        w_sel_idx  = (int'(w_blk_nxt) * NUM_BINS + (NUM_BINS - 1) - int'(w_bin_nxt)) * BIT_WIDTH;
        w_word_sel = w_src[w_sel_idx +: BIT_WIDTH];
    end

    // Output-controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Counters and registered outputs; words only change on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= '0;
            r_bin   <= '0;
            r_blk   <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sob   <= 1'b0;
            r_eob   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_word  <= w_word_nxt;
            r_bin   <= w_bin_nxt;
            r_blk   <= w_blk_nxt;
            r_beat  <= w_beat_nxt;
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_data <= w_word_sel;
                r_sob  <= (w_bin_nxt == '0);
                r_eob  <= (w_bin_nxt == c_LAST_BIN);
                r_sof  <= (w_word_nxt == '0) && (w_beat_nxt == '0);
                r_eof  <= (w_word_nxt == c_LAST_WORD) && (w_beat_nxt == c_LAST_BEAT);
            end
            // A drop wins over a simultaneous clear
            r_ovf <= w_drop | (r_ovf & ~bus.ovf_clr);
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;
    assign bus.out_sob    = r_sob;
    assign bus.out_eob    = r_eob;
    assign bus.out_sof    = r_sof;
    assign bus.out_eof    = r_eof;
    assign bus.ovf        = r_ovf;
    assign bus.fifo_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_hog_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hog_serializer
// Brief    : Scoreboard bench for hog_serializer: a beat-level reference
//            queues the expected word stream, a monitor compares it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hog_serializer;
    import hog_serializer_pkg::*;

    localparam int c_BW    = 12;
    localparam int c_NB    = 9;
    localparam int c_NBLK  = 4;
    localparam int c_DEPTH = 4;
    localparam int c_FB    = 2;
    localparam int c_BLK_W = c_BW * c_NB;
    localparam int c_WORDS = HOG_WORDS_PER_BEAT;

    typedef struct packed {
        logic [c_BW-1:0] data;
        logic            sob;
        logic            eob;
        logic            sof;
        logic            eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hog_serializer_if #(.BIT_WIDTH(c_BW), .NUM_BINS(c_NB), .FIFO_DEPTH(c_DEPTH)) bus ();

    hog_serializer #(
        .BIT_WIDTH   (c_BW),
        .NUM_BINS    (c_NB),
        .NUM_BLOCKS  (c_NBLK),
        .FIFO_DEPTH  (c_DEPTH),
        .FRAME_BEATS (c_FB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    int   m_occ  = 0;   // beats held (including the one being sent)
    int   m_word = 0;   // position within the head beat
    int   m_nacc = 0;   // beats accepted since reset
    logic m_ovf  = 1'b0;
    int   n_xfer = 0;

    // Reference: beat-level occupancy and the word stream each accepted beat implies
    always @(posedge clk or posedge rst) begin : p_model
        bit               xfer, pop, acc;
        logic [c_BLK_W-1:0] blks [c_NBLK];
        logic [c_BLK_W-1:0] t;
        exp_t             e;
        if (rst) begin
            q.delete();
            m_occ  = 0;
            m_word = 0;
            m_nacc = 0;
            m_ovf  = 1'b0;
        end else begin
            xfer = (m_occ > 0) && bus.out_ready;
            pop  = xfer && (m_word == c_WORDS - 1);
            acc  = bus.in_valid && ((m_occ < c_DEPTH) || pop);
            if (xfer) m_word = pop ? 0 : m_word + 1;
            m_occ = m_occ - int'(pop) + int'(acc);
            if (acc) begin
                blks[0] = bus.in_block_0;
                blks[1] = bus.in_block_1;
                blks[2] = bus.in_block_2;
                blks[3] = bus.in_block_3;
                for (int b = 0; b < c_NBLK; b++) begin
                    for (int k = 0; k < c_NB; k++) begin
                        t      = blks[b];
                        e.data = t[c_BW*(c_NB-k)-1 -: c_BW];
                        e.sob  = (k == 0);
                        e.eob  = (k == c_NB - 1);
                        e.sof  = (b == 0) && (k == 0) && ((m_nacc % c_FB) == 0);
                        e.eof  = (b == c_NBLK - 1) && (k == c_NB - 1) && ((m_nacc % c_FB) == c_FB - 1);
                        q.push_back(e);
                    end
                end
                m_nacc++;
            end
            m_ovf = (bus.in_valid && !acc) || (m_ovf && !bus.ovf_clr);
        end
    end

    // Monitor: compare presented word and status against the reference
    always @(negedge clk) begin : p_monitor
        exp_t got;
        checks++;
        if (bus.out_valid !== (m_occ > 0)) begin
            failures++;
            $display("FAIL out_valid got=%b exp=%b t=%0t", bus.out_valid, (m_occ > 0), $time);
        end
        checks++;
        if (bus.fifo_level !== 3'(m_occ)) begin
            failures++;
            $display("FAIL fifo_level got=%0d exp=%0d t=%0t", bus.fifo_level, m_occ, $time);
        end
        checks++;
        if (bus.ovf !== m_ovf) begin
            failures++;
            $display("FAIL ovf got=%b exp=%b t=%0t", bus.ovf, m_ovf, $time);
        end
        if (bus.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected data=%0h t=%0t", bus.out_data, $time);
            end else begin
                got = {bus.out_data, bus.out_sob, bus.out_eob, bus.out_sof, bus.out_eof};
                if (got !== q[0]) begin
                    failures++;
                    $display("FAIL word got data=%0h sob=%b eob=%b sof=%b eof=%b exp data=%0h sob=%b eob=%b sof=%b eof=%b t=%0t",
                             got.data, got.sob, got.eob, got.sof, got.eof,
                             q[0].data, q[0].sob, q[0].eob, q[0].sof, q[0].eof, $time);
                end
                if (bus.out_ready === 1'b1) begin
                    void'(q.pop_front());
                    n_xfer++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [c_BLK_W-1:0] mk_block(input int b, input bit rnd);
        logic [c_BLK_W-1:0] v;
        v = '0;
        for (int k = 0; k < c_NB; k++) begin
            v[c_BW*(c_NB-k)-1 -: c_BW] = rnd ? c_BW'($urandom_range(0, 4095)) : c_BW'(16 * b + k);
        end
        return v;
    endfunction

    task automatic set_blocks(input bit rnd);
        bus.in_block_0 = mk_block(0, rnd);
        bus.in_block_1 = mk_block(1, rnd);
        bus.in_block_2 = mk_block(2, rnd);
        bus.in_block_3 = mk_block(3, rnd);
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while ((m_occ != 0 || q.size() != 0) && n < limit) begin
            cyc();
            n++;
        end
        check({name, "_drain"}, 32'(m_occ != 0 || q.size() != 0), 0);
    endtask

    task automatic wait_model(input int occ, input int word, input int limit, input string name);
        int n;
        n = 0;
        while (!(m_occ == occ && m_word == word) && n < limit) begin
            cyc();
            n++;
        end
        check({name, "_reached"}, 32'(m_occ == occ && m_word == word), 1);
    endtask

    initial begin : p_stim
        bit pat [4];
        int n0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.in_valid  = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.out_ready = 1'b0;
        set_blocks(1'b0);
        repeat (3) cyc();

        // Reset state
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_level", 32'(bus.fifo_level), 0);
        check("rst_ovf",   32'(bus.ovf), 0);
        check("rst_data",  32'(bus.out_data), 0);
        check("rst_flags", 32'({bus.out_sob, bus.out_eob, bus.out_sof, bus.out_eof}), 0);
        rst = 1'b0;
        cyc();

        // Single beat, first-word latency
        n0 = n_xfer;
        bus.out_ready = 1'b1;
        set_blocks(1'b0);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("first_valid", 32'(bus.out_valid), 1);
        check("first_data",  32'(bus.out_data), 0);
        check("first_sof",   32'(bus.out_sof), 1);
        wait_drain(100, "single");
        check("single_words", 32'(n_xfer - n0), 36);

        // Backpressure 1,0,0,1
        n0 = n_xfer;
        set_blocks(1'b1);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 400 && m_occ != 0; i++) begin
            bus.out_ready = pat[i % 4];
            cyc();
        end
        bus.out_ready = 1'b1;
        wait_drain(50, "bp");
        check("bp_words", 32'(n_xfer - n0), 36);

        // Overflow: six beats into a stalled 4-deep FIFO
        bus.out_ready = 1'b0;
        n0 = n_xfer;
        repeat (6) begin
            set_blocks(1'b1);
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        check("ovf_level", 32'(bus.fifo_level), 4);
        check("ovf_flag",  32'(bus.ovf), 1);
        set_blocks(1'b1);
        bus.in_valid = 1'b1;
        bus.ovf_clr  = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        bus.ovf_clr  = 1'b0;
        check("ovf_clr_vs_drop", 32'(bus.ovf), 1);
        bus.out_ready = 1'b1;
        wait_drain(400, "ovf");
        check("ovf_words", 32'(n_xfer - n0), 144);
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", 32'(bus.ovf), 0);

        // Push into a full FIFO while the head retires
        bus.out_ready = 1'b0;
        repeat (4) begin
            set_blocks(1'b1);
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_model(4, c_WORDS - 1, 200, "fullpop");
        set_blocks(1'b1);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("fullpop_level", 32'(bus.fifo_level), 4);
        check("fullpop_ovf",   32'(bus.ovf), 0);
        wait_drain(400, "fullpop");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_blocks(1'b1);
            bus.in_valid  = ($urandom_range(0, 99) < 30);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.ovf_clr   = ($urandom_range(0, 99) < 3);
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain(1000, "random");

        // Reset in the middle of beat 1 with two beats queued
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        repeat (3) begin
            set_blocks(1'b1);
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        wait_model(2, 20, 300, "midrst");
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_level", 32'(bus.fifo_level), 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        set_blocks(1'b0);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("postrst_valid", 32'(bus.out_valid), 1);
        check("postrst_sof",   32'(bus.out_sof), 1);
        wait_drain(100, "postrst");

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
